// File: rtl/dma_rd_sched_if.sv
// dma_rd_sched_if: descriptor, fetch and room-return signals
// between a DMA read scheduler and its channels/read engine.
interface dma_rd_sched_if #(
    parameter int NCH    = 4,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8,
    parameter int ROOM_W = 9
);
    localparam int CH_W = $clog2(NCH);

    logic [NCH-1:0]        chan_enable;
    logic [NCH-1:0]        descp_valid;
    logic [NCH*64-1:0]     descp_data;
    logic [NCH-1:0]        descp_rden;
    logic                  fetch_data;
    logic [CH_W-1:0]       fetch_ch;
    logic [ADDR_W-1:0]     addr_data;
    logic [LEN_W-1:0]      length_data;
    logic                  ack_fetch_data;
    logic [NCH-1:0]        add_room;
    logic [NCH*LEN_W-1:0]  add_value;
    logic [NCH*ROOM_W-1:0] room_avail;
    logic [NCH-1:0]        chan_done;

    modport master (
        output chan_enable, descp_valid, descp_data,
        output ack_fetch_data, add_room, add_value,
        input  descp_rden, fetch_data, fetch_ch,
        input  addr_data, length_data, room_avail, chan_done
    );

    modport slave (
        input  chan_enable, descp_valid, descp_data,
        input  ack_fetch_data, add_room, add_value,
        output descp_rden, fetch_data, fetch_ch,
        output addr_data, length_data, room_avail, chan_done
    );
endinterface

// File: rtl/dma_rd_sched.sv
// dma_rd_sched: round-robin descriptor scheduler issuing one
// outstanding read request at a time, gated by per-channel room.
module dma_rd_sched #(
    parameter int NCH      = 4,
    parameter int ADDR_W   = 32,
    parameter int LEN_W    = 8,
    parameter int ROOM_W   = 9,
    parameter int MAX_ROOM = 256
) (
    input  logic          clk,
    input  logic          rstb,
    dma_rd_sched_if.slave bus
);
    localparam int CH_W = $clog2(NCH);
    // wide enough for room + add without overflow
    localparam int CW = ((ROOM_W > LEN_W) ? ROOM_W : LEN_W) + 1;

    typedef enum logic {ARB, REQ} state_e;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   last_q, last_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              lastf_q, lastf_d;
    logic [ROOM_W-1:0] room_q [NCH];
    logic [ROOM_W-1:0] room_d [NCH];

    logic [ADDR_W-1:0] d_addr [NCH];
    logic [LEN_W-1:0]  d_len  [NCH];
    logic [NCH-1:0]    d_last;
    logic [NCH-1:0]    elig;
    logic [NCH-1:0]    rden;
    logic [NCH-1:0]    done;
    logic [CW-1:0]     sum    [NCH];
    logic              found;
    logic [CH_W-1:0]   gidx;
    logic [CH_W-1:0]   idx;
    logic              ack_fire;
    logic              unused_desc;

    assign unused_desc = ^bus.descp_data;
    assign ack_fire = (state_q == REQ) && bus.ack_fetch_data && !rstb;

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        assign d_addr[n] = bus.descp_data[64*n +: ADDR_W];
        assign d_len[n]  = bus.descp_data[64*n+32 +: LEN_W];
        assign d_last[n] = bus.descp_data[64*n+63];
        assign elig[n]   = bus.chan_enable[n] && bus.descp_valid[n] &&
                           ((d_len[n] == '0) ||
                            (CW'(room_q[n]) >= CW'(d_len[n])));
        assign bus.room_avail[n*ROOM_W +: ROOM_W] = room_q[n];
    end

    assign bus.fetch_data  = (state_q == REQ);
    assign bus.fetch_ch    = ch_q;
    assign bus.addr_data   = addr_q;
    assign bus.length_data = len_q;
    assign bus.descp_rden  = rden;
    assign bus.chan_done   = done;

    // Round-robin grant search, request latch and retire pulses
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        ch_d    = ch_q;
        addr_d  = addr_q;
        len_d   = len_q;
        lastf_d = lastf_q;
        rden    = '0;
        done    = '0;
        found   = 1'b0;
        gidx    = '0;
        idx     = '0;
        unique case (state_q)
            ARB: begin
                for (int i = 1; i <= NCH; i++) begin
                    idx = CH_W'((int'(last_q) + i) % NCH);
                    if (!found && elig[idx]) begin
                        found = 1'b1;
                        gidx  = idx;
                    end
                end
                // no grant is taken while reset is held
                if (found && !rstb) begin
                    if (d_len[gidx] == '0) begin
                        rden[gidx] = 1'b1;
                        done[gidx] = d_last[gidx];
                        last_d     = gidx;
                    end else begin
                        ch_d    = gidx;
                        addr_d  = d_addr[gidx];
                        len_d   = d_len[gidx];
                        lastf_d = d_last[gidx];
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (ack_fire) begin
                    rden[ch_q] = 1'b1;
                    done[ch_q] = lastf_q;
                    last_d     = ch_q;
                    state_d    = ARB;
                end
            end
        endcase
    end

    // Room counters: subtract on ack, add on return, saturate
    always_comb begin
        for (int n = 0; n < NCH; n++) begin
            sum[n] = CW'(room_q[n]);
            if (ack_fire && (ch_q == CH_W'(n))) begin
                sum[n] = sum[n] - CW'(len_q);
            end
            if (bus.add_room[n]) begin
                sum[n] = sum[n] + CW'(bus.add_value[n*LEN_W +: LEN_W]);
            end
            room_d[n] = (sum[n] > CW'(MAX_ROOM)) ?
                        ROOM_W'(MAX_ROOM) : sum[n][ROOM_W-1:0];
        end
    end

    // State, latched request and room registers
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state_q <= ARB;
            last_q  <= CH_W'(NCH - 1);
            ch_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            lastf_q <= 1'b0;
            for (int n = 0; n < NCH; n++) begin
                room_q[n] <= ROOM_W'(MAX_ROOM);
            end
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            ch_q    <= ch_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            lastf_q <= lastf_d;
            for (int n = 0; n < NCH; n++) begin
                room_q[n] <= room_d[n];
            end
        end
    end
endmodule

// File: tb/tb_dma_rd_sched.sv
// tb_dma_rd_sched: directed bench with a request scoreboard
// for the round-robin DMA read scheduler.
module tb_dma_rd_sched;
    localparam int NCH      = 4;
    localparam int ADDR_W   = 32;
    localparam int LEN_W    = 8;
    localparam int ROOM_W   = 9;
    localparam int MAX_ROOM = 256;

    typedef struct {
        int          ch;
        logic [31:0] addr;
        logic [7:0]  len;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rstb;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    dma_rd_sched_if #(
        .NCH(NCH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .ROOM_W(ROOM_W)
    ) bus ();

    dma_rd_sched #(
        .NCH(NCH), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
        .ROOM_W(ROOM_W), .MAX_ROOM(MAX_ROOM)
    ) dut (
        .clk(clk),
        .rstb(rstb),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] room(input int n);
        return bus.room_avail[9*n +: 9];
    endfunction

    task automatic set_desc(input int ch, input logic [31:0] addr,
                            input logic [7:0] len, input logic last);
        logic [63:0] d;
        exp_t e;
        d = '0;
        d[31:0]  = addr;
        d[39:32] = len;
        d[63]    = last;
        bus.descp_data[64*ch +: 64] = d;
        bus.descp_valid[ch] = 1'b1;
        if (len != 8'd0) begin
            e.ch = ch; e.addr = addr; e.len = len; e.last = last;
            sb.push_back(e);
        end
    endtask

    // wait for a request, check it against the scoreboard head,
    // hold it for 'hold' cycles, then ack (with optional add_room)
    task automatic serve(input int hold, input int budget,
                         input logic [3:0] am, input logic [31:0] av,
                         input bit disturb);
        exp_t e;
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (bus.fetch_data === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("req_seen", 64'(seen), 64'd1);
        if (seen) begin
            chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            e = sb.pop_front();
            chk("fetch_ch", 64'(bus.fetch_ch), 64'(e.ch));
            chk("addr_data", 64'(bus.addr_data), 64'(e.addr));
            chk("length_data", 64'(bus.length_data), 64'(e.len));
            for (int k = 0; k < hold; k++) begin
                if (disturb && k == 0) begin
                    bus.chan_enable[e.ch] = 1'b0;
                    bus.descp_data[64*e.ch +: 64] = 64'h0000_0055_DEAD_BEEF;
                end
                #1;
                chk("hold_fetch", 64'(bus.fetch_data), 64'd1);
                chk("hold_addr", 64'(bus.addr_data), 64'(e.addr));
                chk("hold_len", 64'(bus.length_data), 64'(e.len));
                chk("hold_rden", 64'(bus.descp_rden), 64'd0);
                tick();
            end
            bus.ack_fetch_data = 1'b1;
            bus.add_room = am;
            bus.add_value = av;
            #1;
            chk("ack_rden", 64'(bus.descp_rden), 64'(1 << e.ch));
            chk("ack_done", 64'(bus.chan_done),
                e.last ? 64'(1 << e.ch) : 64'd0);
            tick();
            bus.ack_fetch_data = 1'b0;
            bus.add_room = '0;
            bus.add_value = '0;
            bus.descp_valid[e.ch] = 1'b0;
            bus.chan_enable[e.ch] = 1'b1;
            #1;
            chk("post_ack_fetch", 64'(bus.fetch_data), 64'd0);
        end
    endtask

    initial begin
        exp_t e;
        rstb = 1'b1;
        bus.chan_enable = '0;
        bus.descp_valid = '0;
        bus.descp_data = '0;
        bus.ack_fetch_data = 1'b0;
        bus.add_room = '0;
        bus.add_value = '0;
        tick();
        tick();

        // reset state, with a zero-length descriptor presented
        bus.chan_enable = 4'hF;
        set_desc(2, 32'h0, 8'd0, 1'b1);
        #1;
        chk("rst_fetch", 64'(bus.fetch_data), 64'd0);
        chk("rst_rden", 64'(bus.descp_rden), 64'd0);
        chk("rst_done", 64'(bus.chan_done), 64'd0);
        chk("rst_ch", 64'(bus.fetch_ch), 64'd0);
        chk("rst_addr", 64'(bus.addr_data), 64'd0);
        chk("rst_len", 64'(bus.length_data), 64'd0);
        for (int n = 0; n < NCH; n++) chk("rst_room", 64'(room(n)), 64'd256);
        bus.descp_valid[2] = 1'b0;
        tick();
        rstb = 1'b0;
        tick();

        // single channel, ack three cycles after request
        set_desc(0, 32'h1000, 8'd16, 1'b1);
        serve(3, 1, 4'h0, 32'h0, 1'b1);
        chk("single_room0", 64'(room(0)), 64'd240);

        // round-robin from a fresh reset
        rstb = 1'b1;
        tick();
        rstb = 1'b0;
        tick();
        for (int c = 0; c < NCH; c++) set_desc(c, 32'h2000 + 32'(c) * 32'h100, 8'd4, 1'b0);
        serve(0, 2, 4'h0, 32'h0, 1'b0);
        set_desc(0, 32'h2400, 8'd4, 1'b1);
        for (int c = 0; c < NCH; c++) serve(0, 2, 4'h0, 32'h0, 1'b0);
        chk("rr_room0", 64'(room(0)), 64'd248);
        chk("rr_room3", 64'(room(3)), 64'd252);

        // room block on ch1
        set_desc(1, 32'h3000, 8'd244, 1'b0);
        serve(0, 2, 4'h0, 32'h0, 1'b0);
        chk("blk_room1", 64'(room(1)), 64'd8);
        set_desc(2, 32'h3200, 8'd4, 1'b0);
        set_desc(0, 32'h3300, 8'd4, 1'b0);
        set_desc(1, 32'h3100, 8'd16, 1'b1);
        serve(0, 2, 4'h0, 32'h0, 1'b0);
        serve(0, 2, 4'h0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("blk_idle_fetch", 64'(bus.fetch_data), 64'd0);
            chk("blk_idle_rden", 64'(bus.descp_rden), 64'd0);
        end
        chk("blk_room1_hold", 64'(room(1)), 64'd8);
        bus.add_room = 4'b0010;
        bus.add_value = 32'd8 << 8;
        tick();
        bus.add_room = '0;
        bus.add_value = '0;
        chk("blk_room1_add", 64'(room(1)), 64'd16);
        serve(0, 2, 4'h0, 32'h0, 1'b0);
        chk("blk_room1_end", 64'(room(1)), 64'd0);

        // simultaneous subtract and add, then saturation
        set_desc(2, 32'h4000, 8'd148, 1'b0);
        serve(0, 2, 4'h0, 32'h0, 1'b0);
        chk("sim_room2_100", 64'(room(2)), 64'd100);
        set_desc(2, 32'h4100, 8'd10, 1'b1);
        serve(1, 2, 4'b0100, 32'd4 << 16, 1'b0);
        chk("sim_room2_94", 64'(room(2)), 64'd94);
        set_desc(3, 32'h5000, 8'd152, 1'b0);
        serve(0, 2, 4'h0, 32'h0, 1'b0);
        chk("sat_room3_100", 64'(room(3)), 64'd100);
        bus.add_room = 4'b1000;
        bus.add_value = 32'd200 << 24;
        tick();
        bus.add_room = '0;
        bus.add_value = '0;
        chk("sat_room3", 64'(room(3)), 64'd256);

        // zero-length descriptor with last flag
        set_desc(3, 32'h6000, 8'd0, 1'b1);
        #1;
        chk("zl_rden", 64'(bus.descp_rden), 64'b1000);
        chk("zl_done", 64'(bus.chan_done), 64'b1000);
        chk("zl_fetch", 64'(bus.fetch_data), 64'd0);
        tick();
        bus.descp_valid[3] = 1'b0;
        #1;
        chk("zl_fetch_after", 64'(bus.fetch_data), 64'd0);
        chk("zl_room3", 64'(room(3)), 64'd256);

        // reset in the middle of a request
        set_desc(0, 32'h7000, 8'd20, 1'b1);
        tick();
        chk("mid_fetch", 64'(bus.fetch_data), 64'd1);
        e = sb.pop_front();
        chk("mid_addr", 64'(bus.addr_data), 64'(e.addr));
        rstb = 1'b1;
        bus.ack_fetch_data = 1'b1;
        #1;
        chk("mid_rst_fetch", 64'(bus.fetch_data), 64'd0);
        chk("mid_rst_rden", 64'(bus.descp_rden), 64'd0);
        chk("mid_rst_addr", 64'(bus.addr_data), 64'd0);
        for (int n = 0; n < NCH; n++) chk("mid_rst_room", 64'(room(n)), 64'd256);
        tick();
        chk("mid_rst_rden2", 64'(bus.descp_rden), 64'd0);
        bus.ack_fetch_data = 1'b0;
        bus.descp_valid = '0;
        rstb = 1'b0;
        tick();
        chk("mid_post_fetch", 64'(bus.fetch_data), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dma_rd_sched.md
DMA_RD_SCHED -- requirements
Module: dma_rd_sched

Interface
REQ-001 Parameter NCH, default 4: number of read channels (2..8).
REQ-002 Parameter ADDR_W, default 32: data address width.
REQ-003 Parameter LEN_W, default 8: request length width, in dwords.
REQ-004 Parameter ROOM_W, default 9: per-channel room counter width.
REQ-005 Parameter MAX_ROOM, default 256: room counter reset and saturation value.
REQ-006 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 Port rstb, input, 1: reset, asynchronous and active-high.
REQ-008 Port chan_enable, input, NCH: per-channel enable; a disabled channel is never granted.
REQ-009 Port descp_valid, input, NCH: channel n has a descriptor at the head of its descriptor FIFO.
REQ-010 Port descp_data, input, NCH*64: head descriptor of channel n at bits [64n+63:64n].
- [31:0] is the data address, low ADDR_W bits used.
- [32+LEN_W-1:32] is the length.
- [63] is the last flag.
REQ-011 Port descp_rden, output, NCH: one-cycle pop pulse to channel n's descriptor FIFO.
REQ-012 Port fetch_data, output, 1: data read request.
REQ-013 Port fetch_ch, output, clog2(NCH): channel of the current request.
REQ-014 Port addr_data, output, ADDR_W: address of the current request.
REQ-015 Port length_data, output, LEN_W: length of the current request.
REQ-016 Port ack_fetch_data, input, 1: request accepted.
REQ-017 Port add_room, input, NCH: channel n consumer returns add_value slice n of room.
REQ-018 Port add_value, input, NCH*LEN_W: per-channel returned dwords.
REQ-019 Port room_avail, output, NCH*ROOM_W: per-channel room counters.
REQ-020 Port chan_done, output, NCH: one-cycle pulse when a descriptor with the last flag set is retired.

Function
REQ-021 The state machine SHALL have exactly two states, ARB and REQ.
REQ-022 In ARB, channel n SHALL be eligible when all of the following hold:
- chan_enable[n] is 1;
- descp_valid[n] is 1;
- length is 0, or room_avail[n] >= length.
REQ-023 Grant SHALL be round-robin, starting the search at last_grant+1 modulo NCH; last_grant SHALL reset to NCH-1.
REQ-024 For a granted descriptor with length 0, the block SHALL:
- pulse descp_rden[n] in the grant cycle;
- issue no request;
- set last_grant to n;
- remain in ARB;
- pulse chan_done[n] in the same cycle if the last flag is set.
REQ-025 For a granted descriptor with length greater than 0, the block SHALL latch fetch_ch, addr_data and length_data, and enter REQ with fetch_data=1 on the next cycle (1-cycle grant-to-request latency).
REQ-026 In REQ, fetch_data, fetch_ch, addr_data and length_data SHALL hold stable until ack_fetch_data=1.
REQ-027 On the ack cycle, the block SHALL:
- pulse descp_rden[fetch_ch];
- subtract length_data from room_avail[fetch_ch];
- pulse chan_done[fetch_ch] if the latched last flag is set;
- set last_grant to fetch_ch;
- return to ARB, with fetch_data=0 on the next cycle.
REQ-028 ack_fetch_data SHALL be ignored outside REQ.
REQ-029 At most one request SHALL be outstanding, and at most one descp_rden bit SHALL be high per cycle.
REQ-030 Each room counter SHALL update as room - sub + add in a single cycle, so a simultaneous subtract and add are both applied.
REQ-031 A room counter result above MAX_ROOM SHALL saturate at MAX_ROOM; the counter SHALL never go negative, because grant requires room >= length.
REQ-032 Deasserting chan_enable[n] while in REQ for channel n SHALL NOT abort the request; the request completes normally.
REQ-033 Changes to descp_valid or descp_data in REQ SHALL NOT affect the latched request.

Reset
REQ-034 While rstb=1, the block SHALL be in ARB with:
- fetch_data, descp_rden and chan_done all 0;
- fetch_ch, addr_data and length_data all 0;
- every room_avail slice equal to MAX_ROOM;
- last_grant equal to NCH-1.
REQ-035 Reset asserted mid-request SHALL drop the request immediately, with no descp_rden and no room change.
REQ-036 The first grant after reset release SHALL occur no earlier than the first rising edge with rstb=0.

Verification
REQ-037 The bench SHALL cover single channel: ch0 enabled, descriptor {addr 0x1000, len 16, last 1}, ack 3 cycles after request.
- Required response: fetch_data=1 one cycle after valid.
- Request held for 3 cycles.
- On the ack cycle, descp_rden[0] and chan_done[0] pulse.
- room_avail[0] reads 240.
REQ-038 The bench SHALL cover round-robin: all 4 channels valid, len 4, ack immediate.
- Required response: fetch_ch sequence 0,1,2,3,0.
REQ-039 The bench SHALL cover room block: room_avail[1]=8 with a descriptor of len 16.
- Required response: ch1 is skipped while other channels are served.
- After add_room[1] with add_value 8, ch1 is granted within 2 cycles.
REQ-040 The bench SHALL cover simultaneous update: ack for ch2 (len 10) in the same cycle as add_room[2] with add_value 4, from room 100.
- Required response: room_avail[2]=94.
- Add 200 to a counter at 100: the counter saturates at 256.
REQ-041 The bench SHALL cover a zero-length descriptor: ch3 {len 0, last 1}.
- Required response: descp_rden[3] and chan_done[3] pulse together.
- fetch_data stays 0.
REQ-042 The bench SHALL cover reset mid-request: rstb=1 during REQ.
- Required response: fetch_data=0 immediately.
- No pop occurs, and all rooms read 256.
